// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the two requester ports, the RAM port and the
// status outputs of mem_arbiter.
//   Requester m0 (CPU) / m1 (debug/loader): *_req, *_we, *_addr, *_wdata in,
//     *_ack, *_err, *_rdata out; m1_lock lets m1 reserve the bus.
//   RAM side: mem_addr, mem_wdata, mem_oe, mem_we out, mem_rdata in.
//   Status: cpu_stall, busy.
// Modport master is the arbiter's view; modport slave is the view of the
// requesters plus RAM that surround it.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_lock;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_oe;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  cpu_stall;
  logic                  busy;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_rdata,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_addr, mem_wdata, mem_oe, mem_we,
    output cpu_stall, busy
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_rdata,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_addr, mem_wdata, mem_oe, mem_we,
    input  cpu_stall, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester round-robin arbiter in front of a single-port
// RAM. m0 is the CPU, m1 a debug/loader port that can lock the bus.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_arbiter_if.master (requester handshakes, RAM port,
//           cpu_stall, busy)
// Read: grant, RD_ADDR (oe), RD_DATA (oe, capture), ack. Write: grant,
// WR (we, one cycle), ack.
// Optional feature: define MEM_ARB_RANGE_CHECK_EN to reject any access whose
// address MSB is set (ERR state, ack+err pulse, rdata cleared for reads).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR
`ifdef MEM_ARB_RANGE_CHECK_EN
    , ERR
`endif
  } state_t;

  state_t                state;
  logic                  owner;       // 0 = m0, 1 = m1
  logic                  last_grant;  // 0 = m0, 1 = m1
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_oe_q, mem_we_q;

`ifdef MEM_ARB_RANGE_CHECK_EN
  logic                  err0, err1;
  logic                  lat_we;
`endif

  logic                  elig0, elig1, grant, sel, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A requester whose ack is high this cycle is finishing and must not be
  // re-granted on its still-asserted req.
  always_comb begin
    elig0     = bus.m0_req & ~ack0 & ~bus.m1_lock;
    elig1     = bus.m1_req & ~ack1;
    grant     = elig0 | elig1;
    sel       = (elig0 & elig1) ? ~last_grant : elig1;
    sel_we    = sel ? bus.m1_we    : bus.m0_we;
    sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
`ifdef MEM_ARB_RANGE_CHECK_EN
      err0        <= 1'b0;
      err1        <= 1'b0;
      lat_we      <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
`ifdef MEM_ARB_RANGE_CHECK_EN
      err0 <= 1'b0;
      err1 <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= sel;
            last_grant <= sel;
`ifdef MEM_ARB_RANGE_CHECK_EN
            lat_we     <= sel_we;
            if (sel_addr[ADDR_WIDTH-1]) begin
              state <= ERR;
            end else
`endif
            if (sel_we) begin
              state       <= WR;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end else begin
              state      <= RD_ADDR;
              mem_oe_q   <= 1'b1;
              mem_addr_q <= sel_addr;
            end
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          state    <= IDLE;
          mem_oe_q <= 1'b0;
          if (owner) begin
            ack1   <= 1'b1;
            rdata1 <= bus.mem_rdata;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= bus.mem_rdata;
          end
        end
        WR: begin
          state    <= IDLE;
          mem_we_q <= 1'b0;
          if (owner) ack1 <= 1'b1;
          else       ack0 <= 1'b1;
        end
`ifdef MEM_ARB_RANGE_CHECK_EN
        ERR: begin
          state <= IDLE;
          if (owner) begin
            ack1 <= 1'b1;
            err1 <= 1'b1;
            if (!lat_we) rdata1 <= '0;
          end else begin
            ack0 <= 1'b1;
            err0 <= 1'b1;
            if (!lat_we) rdata0 <= '0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack    = ack0;
  assign bus.m1_ack    = ack1;
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = (state != IDLE);
`ifdef MEM_ARB_RANGE_CHECK_EN
  assign bus.m0_err    = err0;
  assign bus.m1_err    = err1;
`else
  assign bus.m0_err    = 1'b0;
  assign bus.m1_err    = 1'b0;
`endif

  // Lock must stall the CPU in the same cycle it is raised, so it bypasses
  // the state register; reset masks it so stall reads 0 while in reset.
  assign bus.cpu_stall = ~reset & (bus.m1_lock | (owner & (state != IDLE)));

endmodule
